// File: rtl/riscv_pkg.sv
// Shared types for the data-memory responder.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_ILL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int unsigned DMEM_LANES = 4;
  localparam int unsigned DMEM_CNT_W = 4;

  // Byte-lane enables for an access of the given size at lane offset off.
  function automatic logic [DMEM_LANES-1:0] lane_mask(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_B:   lane_mask = 4'b0001 << off;
      MEM_H:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      MEM_W:   lane_mask = 4'b1111;
      default: lane_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_ram.sv
// Word-addressed storage with per-byte write enables and combinational read.
module riscv_dmem_ram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned DW          = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DMEM_LANES-1:0] be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  output logic [DW-1:0]         rdata_o
);

  localparam int unsigned LW = DW / DMEM_LANES;

  logic [DW-1:0] mem [DEPTH_WORDS];

  // Byte-enabled write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < DMEM_LANES; i++) begin
        if (be_i[i]) begin
          mem[addr_i][i*LW +: LW] <= wdata_i[i*LW +: LW];
        end
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/riscv_dmem.sv
// MEM-stage data memory responder: one request in flight, fixed latency,
// byte/half/word access with lane steering and load extension.
module riscv_dmem
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [WORD_SIZE-1:0] req_addr_i,
  input  logic [WORD_SIZE-1:0] req_wdata_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WORD_SIZE-1:0] rsp_rdata_o,
  output logic                 rsp_err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);
  localparam logic [WORD_SIZE-3:0] DEPTH_LIM = (WORD_SIZE-2)'(DEPTH_WORDS);

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
  logic                  err_q;

  mem_size_e             size;
  logic [1:0]            lane;
  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;

  logic                  ram_we;
  logic [DMEM_LANES-1:0] ram_be;
  logic [WORD_SIZE-1:0]  ram_wdata;
  logic [WORD_SIZE-1:0]  ram_rdata;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [WORD_SIZE-1:0]  ld_data;

  assign size        = mem_size_e'(req_size_i);
  assign lane        = req_addr_i[1:0];
  assign req_ready_o = (state_q == IDLE) && rst_ni;
  assign accept      = req_valid_i && req_ready_o;

  // Alignment and size legality; illegal size is folded in as "misaligned".
  always_comb begin
    misaligned = 1'b0;
    case (size)
      MEM_B:   misaligned = 1'b0;
      MEM_H:   misaligned = lane[0];
      MEM_W:   misaligned = |lane;
      default: misaligned = 1'b1;
    endcase
  end

  assign out_of_range = req_addr_i[WORD_SIZE-1:2] >= DEPTH_LIM;
  assign req_err      = misaligned || out_of_range;

  // Replicate narrow store data across lanes; byte enables pick the target.
  always_comb begin
    ram_wdata = req_wdata_i;
    case (size)
      MEM_B:   ram_wdata = {(WORD_SIZE/8){req_wdata_i[7:0]}};
      MEM_H:   ram_wdata = {(WORD_SIZE/16){req_wdata_i[15:0]}};
      default: ram_wdata = req_wdata_i;
    endcase
  end

  assign ram_be = lane_mask(size, lane);
  assign ram_we = accept && req_we_i && !req_err;

  riscv_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW),
    .DW         (WORD_SIZE)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .addr_i (req_addr_i[AW+1:2]),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign ld_byte = ram_rdata[{lane, 3'b000} +: 8];
  assign ld_half = ram_rdata[{lane[1], 4'b0000} +: 16];

  // Load alignment and sign/zero extension.
  always_comb begin
    ld_data = ram_rdata;
    case (size)
      MEM_B:   ld_data = {{(WORD_SIZE-8){ld_byte[7] && !req_unsigned_i}}, ld_byte};
      MEM_H:   ld_data = {{(WORD_SIZE-16){ld_half[15] && !req_unsigned_i}}, ld_half};
      default: ld_data = ram_rdata;
    endcase
  end

  assign rdata_d = (req_err || req_we_i) ? '0 : ld_data;

  // State, latency counter and response capture at the acceptance edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rdata_q <= rdata_d;
        err_q   <= req_err;
      end
    end
  end

  // Next-state: IDLE accepts, WAIT counts down the remaining latency, RESP holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - DMEM_CNT_W'(1);
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: doc/riscv_dmem.md
# riscv_dmem

Data memory responder for the RISC-V pipeline's MEM stage. It accepts one load or store request at a time over a valid/ready handshake, performs byte/halfword/word access on an internal word-addressed array with lane steering and sign/zero extension, and returns a response after a configurable latency. Misaligned, out-of-range, or illegal-size requests are rejected with an error flag and never modify memory.

## Interface
- WORD_SIZE, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 1, cycles from the acceptance edge to `rsp_valid_o` rising; legal range 1..15.

- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  WORD_SIZE  byte address.
- req_wdata_i  in  WORD_SIZE  store data, right-justified.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend loads (LBU/LHU); ignored for word and stores.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  MEM stage takes the response.
- rsp_rdata_o  out  WORD_SIZE  load data, extended; 0 for stores and errors.
- rsp_err_o  out  1  request rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- `req_ready_o` = (state == IDLE) && rst_ni.
- IDLE: on `req_valid_i && req_ready_o` at a rising edge:
  - Latch the response.
  - Commit the store if legal.
  - Load counter with LATENCY-1.
  - Go to RESP if LATENCY == 1; otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP on the next edge.
- RESP: hold `rsp_valid_o`, `rsp_rdata_o`, and `rsp_err_o` stable until `rsp_ready_i`. Return to IDLE on the handshake edge.
- Requests are never accepted in WAIT or RESP.
- Legality: the request is an error if any of these hold:
  - Size 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] ≠ 00.
  - addr[WORD_SIZE-1:2] ≥ DEPTH_WORDS.

  An error request writes nothing. It returns `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
- Store: write lane addr[1:0] (byte) or lanes addr[1]*2 +: 2 (half) or all 4 lanes, taking the low bytes of `req_wdata_i`. Other lanes are unchanged.
- Load: select the byte or half at the lane offset. Sign-extend bit 7/15 unless `req_unsigned_i`. Read data is sampled at the acceptance edge, so a load sees all prior committed stores.
- Array contents are not reset. Reading never-written locations returns X in simulation.

## Timing
- Reset values:
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - `req_ready_o` = 0 while `rst_ni` is low, 1 after release.
  - Counter = 0.
- Latency: `rsp_valid_o` rises exactly LATENCY cycles after the acceptance edge.
- Minimum request spacing is LATENCY+1 cycles when `rsp_ready_i` is held high.
- `rsp_ready_i` already high when RESP is entered: the handshake completes on the first RESP edge.
- Backpressure: the response is held indefinitely, and `req_ready_o` stays 0.
- Reset mid-operation (WAIT or RESP):
  - Response is dropped and outputs clear immediately (asynchronous).
  - A store accepted before the reset remains committed.
- A store followed by a load to the same word returns the new data.

## Structure
- `riscv_pkg` holds:
  - `mem_size_e` (MEM_B, MEM_H, MEM_W, MEM_ILL).
  - `dmem_state_e` (IDLE, WAIT, RESP).
- One sub-module, `riscv_dmem_ram`: a DEPTH_WORDS×32 array with a 4-bit byte-enable write and a combinational read.
- The FSM, legality check, lane steering, and extension live in `riscv_dmem`.

## Test plan
- LATENCY = 1, rsp_ready_i = 1:
  - SW 0xDEADBEEF @0x10, then LW @0x10: `rsp_rdata_o` = 0xDEADBEEF.
  - `rsp_valid_o` is high the cycle after each acceptance.
  - Requests are accepted every 2 cycles.
- After the word above, SB 0x5A @0x13:
  - LW @0x10 = 0x5AADBEEF.
  - LB @0x13 = 0x0000005A.
  - LB @0x12 = 0xFFFFFFAD; LBU @0x12 = 0x000000AD.
  - LH @0x12 = 0x00005AAD.
- Error requests:
  - LH @0x11 → `rsp_err_o` = 1, `rsp_rdata_o` = 0.
  - SW @0x12 → error; a later LW @0x10 is unchanged.
  - SW @ 4*DEPTH_WORDS → error.
  - Size 11 → error.
- LATENCY = 3 with `rsp_ready_i` low for 5 cycles:
  - `rsp_valid_o` rises 3 cycles after acceptance and holds stable data.
  - `req_ready_o` = 0 throughout.
  - Back to IDLE one edge after `rsp_ready_i` rises.
- Reset during WAIT after an accepted SW 0x12345678 @0x20:
  - Outputs clear immediately; `req_ready_o` returns 1 after release.
  - LW @0x20 returns 0x12345678.
- Random valid/ready backpressure, 10k mixed requests, checked against a byte-array reference model: no lost or duplicated responses.
